// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, ALUOp encodings and the hazard scheduler state.
package pipe_pkg;

  localparam logic [5:0] OP_R      = 6'h00;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_BRANCH = 6'h04;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_MDU    = 6'h1C;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_MDU_DONE = 2'd2
  } hz_state_e;

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic rt_used(input logic [5:0] op);
    return (op == OP_R) || (op == OP_SW) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_sched_if.sv
// Hazard scheduler bundle: pipeline status in, register/PC control strobes out.
interface hazard_sched_if #(
  parameter int unsigned STAT_W = 16
);
  logic [5:0]        id_opcode;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              ex_mem_read;
  logic [4:0]        ex_rt;
  logic              ex_mdu_start;
  logic              mem_branch;
  logic              mem_zero;
  logic              pc_write;
  logic              pc_src;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_write;
  logic              idex_bubble;
  logic              exmem_bubble;
  logic              mdu_busy;
  logic [STAT_W-1:0] stall_cycles;

  modport master (
    output id_opcode, id_rs, id_rt, ex_mem_read, ex_rt, ex_mdu_start, mem_branch, mem_zero,
    input  pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble,
           mdu_busy, stall_cycles
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, ex_mem_read, ex_rt, ex_mdu_start, mem_branch, mem_zero,
    output pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble,
           mdu_busy, stall_cycles
  );
endinterface

// File: rtl/mdu_timer.sv
// Loadable down-counter tracking remaining MDU hold cycles; never underflows.
module mdu_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: branch flush, MDU hold sequencing and load-use stalls.
module hazard_sched
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_LAT = 32,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned STAT_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_sched_if.slave hz
);

  localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_LAT - 2);

  hz_state_e         state_q, state_d;
  logic [CNT_W-1:0]  tmr_cnt;
  logic              tmr_zero;
  logic              tmr_clr, tmr_load, tmr_dec;
  logic [STAT_W-1:0] stall_q;

  logic load_use, br_taken;
  logic pc_write_c, pc_src_c, ifid_write_c, ifid_flush_c;
  logic idex_write_c, idex_bubble_c, exmem_bubble_c, mdu_busy_c;

  assign load_use = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                    ((hz.ex_rt == hz.id_rs) || (rt_used(hz.id_opcode) && (hz.ex_rt == hz.id_rt)));
  assign br_taken = hz.mem_branch && hz.mem_zero;

  mdu_timer #(.CNT_W(CNT_W)) u_mdu_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (MDU_LOAD),
    .dec      (tmr_dec),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority: taken branch, then MDU hold, then load-use stall.
  always_comb begin
    state_d        = state_q;
    tmr_clr        = 1'b0;
    tmr_load       = 1'b0;
    tmr_dec        = 1'b0;
    pc_write_c     = 1'b1;
    pc_src_c       = 1'b0;
    ifid_write_c   = 1'b1;
    ifid_flush_c   = 1'b0;
    idex_write_c   = 1'b1;
    idex_bubble_c  = 1'b0;
    exmem_bubble_c = 1'b0;
    mdu_busy_c     = (state_q != ST_RUN);

    if (br_taken) begin
      pc_src_c       = 1'b1;
      ifid_flush_c   = 1'b1;
      idex_bubble_c  = 1'b1;
      exmem_bubble_c = 1'b1;
      if (state_q != ST_RUN) begin
        state_d = ST_RUN;
        tmr_clr = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (hz.ex_mdu_start) begin
            pc_write_c     = 1'b0;
            ifid_write_c   = 1'b0;
            idex_write_c   = 1'b0;
            exmem_bubble_c = 1'b1;
            mdu_busy_c     = 1'b1;
            tmr_load       = 1'b1;
            state_d        = (MDU_LAT <= 2) ? ST_MDU_DONE : ST_MDU_WAIT;
          end else if (load_use) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
          end
        end
        ST_MDU_WAIT: begin
          pc_write_c     = 1'b0;
          ifid_write_c   = 1'b0;
          idex_write_c   = 1'b0;
          exmem_bubble_c = 1'b1;
          tmr_dec        = 1'b1;
          // Leave on the cycle the counter steps down to zero.
          if (tmr_zero || (tmr_cnt == CNT_W'(1))) begin
            state_d = ST_MDU_DONE;
          end
        end
        ST_MDU_DONE: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!pc_write_c && (stall_q != '1)) begin
      stall_q <= stall_q + STAT_W'(1);
    end
  end

  assign hz.pc_write     = pc_write_c;
  assign hz.pc_src       = pc_src_c;
  assign hz.ifid_write   = ifid_write_c;
  assign hz.ifid_flush   = ifid_flush_c;
  assign hz.idex_write   = idex_write_c;
  assign hz.idex_bubble  = idex_bubble_c;
  assign hz.exmem_bubble = exmem_bubble_c;
  assign hz.mdu_busy     = mdu_busy_c;
  assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched with MDU_LAT=4; output strobes packed into one byte.
module tb_hazard_sched;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [15:0] exp_stall;

  hazard_sched_if #(.STAT_W(16)) hz ();

  hazard_sched #(.MDU_LAT(4), .CNT_W(6), .STAT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, mdu_busy}
  localparam logic [7:0] V_NORM  = 8'hA8;
  localparam logic [7:0] V_LU    = 8'h0C;
  localparam logic [7:0] V_HOLD  = 8'h03;
  localparam logic [7:0] V_DONE  = 8'hA9;
  localparam logic [7:0] V_BR    = 8'hFE;
  localparam logic [7:0] V_BRMDU = 8'hFF;

  function automatic logic [7:0] outv();
    return {hz.pc_write, hz.pc_src, hz.ifid_write, hz.ifid_flush,
            hz.idex_write, hz.idex_bubble, hz.exmem_bubble, hz.mdu_busy};
  endfunction

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] exrt, input logic mdu,
                       input logic br, input logic zr);
    hz.id_opcode    = op;
    hz.id_rs        = rs;
    hz.id_rt        = rt;
    hz.ex_mem_read  = mr;
    hz.ex_rt        = exrt;
    hz.ex_mdu_start = mdu;
    hz.mem_branch   = br;
    hz.mem_zero     = zr;
  endtask

  task automatic idle();
    drive(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sample at the falling edge, then advance past the next rising edge.
  task automatic chk(input string name, input logic [7:0] exp);
    @(negedge clk);
    n_cmp++;
    if (outv() !== exp) begin
      n_err++;
      $display("FAIL %s: outputs got %h expected %h", name, outv(), exp);
    end
    if (!exp[7] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall(input string name);
    n_cmp++;
    if (hz.stall_cycles !== exp_stall) begin
      n_err++;
      $display("FAIL %s: stall_cycles got %0d expected %0d", name, hz.stall_cycles, exp_stall);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #12;
    n_cmp++;
    if (outv() !== V_NORM) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected %h", outv(), V_NORM);
    end
    chk_stall("reset_stall");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    drive(6'h00, 5'd2, 5'd3, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    chk("lu_rs_stall", V_LU);
    idle();
    chk("lu_after", V_NORM);
    chk_stall("lu_stall_count");
    drive(6'h2B, 5'd7, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    chk("lu_sw_rt", V_LU);
    drive(6'h04, 5'd1, 5'd12, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0);
    chk("lu_beq_rt", V_LU);
    idle();
    chk("lu_idle", V_NORM);
    chk_stall("lu_stall_count2");
  endtask

  task automatic test_no_hazard();
    drive(6'h00, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("nh_zero_reg", V_NORM);
    drive(6'h08, 5'd4, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("nh_addi_rt", V_NORM);
    drive(6'h00, 5'd6, 5'd6, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0);
    chk("nh_no_load", V_NORM);
    drive(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("nh_branch_not_taken", V_NORM);
    chk_stall("nh_stall_count");
  endtask

  task automatic test_mdu();
    drive(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("mdu_c1", V_HOLD);
    idle();
    chk("mdu_c2", V_HOLD);
    drive(6'h00, 5'd2, 5'd0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    chk("mdu_c3_lu_ignored", V_HOLD);
    drive(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("mdu_done_start_ignored", V_DONE);
    idle();
    chk("mdu_back_to_run", V_NORM);
    chk_stall("mdu_stall_count");
  endtask

  task automatic test_branch_abort();
    drive(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("ba_start", V_HOLD);
    idle();
    chk("ba_wait1", V_HOLD);
    drive(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("ba_flush", V_BRMDU);
    idle();
    chk("ba_run_next", V_NORM);
    chk_stall("ba_stall_count");
  endtask

  task automatic test_branch_loaduse();
    drive(6'h00, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1);
    chk("bl_flush_only", V_BR);
    idle();
    chk("bl_idle", V_NORM);
    chk_stall("bl_no_stall");
    drive(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    chk("bl_branch_over_mdu", V_BR);
    idle();
    chk("bl_no_mdu", V_NORM);
  endtask

  task automatic test_saturation();
    int bad;
    bad = 0;
    drive(6'h00, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65541; i++) begin
      @(negedge clk);
      if (hz.pc_write !== 1'b0) bad++;
      @(posedge clk);
    end
    #1;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL sat_pc_write: %0d cycles had pc_write high, expected 0", bad);
    end
    idle();
    @(negedge clk);
    exp_stall = 16'hFFFF;
    chk_stall("sat_value");
    @(posedge clk);
    #1;
    chk_stall("sat_hold");
  endtask

  task automatic test_reset_mid_mdu();
    drive(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("rm_start", V_HOLD);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    exp_stall = 16'd0;
    n_cmp++;
    if (outv() !== V_NORM) begin
      n_err++;
      $display("FAIL rm_outputs: got %h expected %h", outv(), V_NORM);
    end
    chk_stall("rm_stall_cleared");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rm_run_after", V_NORM);
    chk("rm_run_after2", V_NORM);
    chk_stall("rm_stall_still_zero");
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    exp_stall = 16'd0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mdu();
    test_branch_abort();
    test_branch_loaduse();
    test_saturation();
    test_reset_mid_mdu();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
Pipeline hazard controller/scheduler for the 5-stage MIPS core; sequences the IF/ID/EX/MEM pipeline registers around the EX-stage datapath configured by the EX control fields (RegDst, ALUOp, ALUSrc).
Detects load-use hazards, applies taken-branch flushes, and holds EX for a multi-cycle multiply/divide unit (MDU) with a countdown FSM.
Sits beside the control unit; drives write-enables and bubble/flush strobes of pipeline registers and the PC.

Parameters:
MDU_LAT, 32, MDU occupancy in cycles (>=2)
CNT_W, 6, counter width; must hold MDU_LAT-1
STAT_W, 16, width of stall-cycle statistic counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
id_opcode  in  6  Instruction[31:26] of instruction in ID
id_rs  in  5  rs field in ID
id_rt  in  5  rt field in ID
ex_mem_read  in  1  instruction in EX is LW
ex_rt  in  5  destination rt of instruction in EX
ex_mdu_start  in  1  instruction in EX is an MDU op
mem_branch  in  1  Branch control bit of instruction in MEM
mem_zero  in  1  ALU zero flag latched into EX/MEM
pc_write  out  1  PC update enable
pc_src  out  1  1 = select branch target
ifid_write  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID clear to NOP
idex_write  out  1  ID/EX register enable
idex_bubble  out  1  ID/EX load all-zero control
exmem_bubble  out  1  EX/MEM load all-zero control
mdu_busy  out  1  MDU sequence active
stall_cycles  out  STAT_W  saturating count of stall cycles

Behaviour:
- Reset (rst_n=0, async): state=RUN, mdu_cnt=0, stall_cycles=0; outputs pc_write=1, ifid_write=1, idex_write=1, all flush/bubble=0, pc_src=0, mdu_busy=0.
- State and counters registered on clk; all other outputs combinational from state + current inputs (zero-cycle latency).
- States: RUN, MDU_WAIT, MDU_DONE.
- rt_used = id_opcode is R-type (6'h00), SW (6'h2B) or BEQ (6'h04); otherwise only rs is a source.
- load_use = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (rt_used & ex_rt==id_rt)).
- br_taken = mem_branch & mem_zero.
- Priority: br_taken > MDU hold > load_use.
- br_taken (any state): pc_src=1, pc_write=1, ifid_flush=1, idex_bubble=1, exmem_bubble=1; if state is MDU_WAIT/MDU_DONE, abort: next state RUN, mdu_cnt=0. Not counted as a stall.
- RUN & ex_mdu_start & !br_taken: next state MDU_WAIT, mdu_cnt<=MDU_LAT-2; this cycle pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1.
- MDU_WAIT: same hold outputs; mdu_cnt decrements; at mdu_cnt==0 next state MDU_DONE.
- MDU_DONE: all enables 1, no bubble (MDU result enters EX/MEM), next state RUN; ex_mdu_start ignored this cycle.
- Total EX occupancy of an MDU op = MDU_LAT cycles (MDU_LAT-1 hold cycles + MDU_DONE).
- RUN & load_use & no higher event: pc_write=0, ifid_write=0, idex_bubble=1 for exactly that cycle; the next cycle the LW has left EX, so no repeat.
- load_use during MDU_WAIT is ignored (hold already covers it).
- mdu_busy=1 in MDU_WAIT and MDU_DONE.
- stall_cycles increments by 1 every cycle with pc_write=0; saturates at all-ones, never wraps.
- rst_n asserted mid-MDU: immediate return to reset values; no partial state survives.

Decomposition:
- Shared package pipe_pkg: opcode constants (R_, Lw_, Sw_, Branch_, Addi_, Addiu_, Ori_, MDU opcode), ALUOp encodings, state enum.
- One sub-module: mdu_timer (loadable down-counter with zero flag, CNT_W parameter) instantiated for mdu_cnt.

Test Plan:
- LW $2 in EX (ex_mem_read=1, ex_rt=2), ID ADD using rs=2 -> 1 cycle pc_write=0, idex_bubble=1; then normal flow; stall_cycles=1.
- ex_rt=0 with ex_mem_read=1 and id_rs=0 -> no stall; ADDI with id_rt==ex_rt, rs differs -> no stall (rt unused).
- ex_mdu_start pulse, MDU_LAT=4 -> pc_write=0 for exactly 3 cycles, MDU_DONE on cycle 4, mdu_busy high 4 cycles, stall_cycles=3.
- br_taken on 2nd cycle of MDU_WAIT -> pc_src=1, all flush/bubble=1 that cycle, state RUN next cycle, mdu_busy=0.
- br_taken and load_use in same cycle -> flush outputs only, pc_write=1, no stall counted.
- Force 2^STAT_W+5 stall cycles -> stall_cycles holds 16'hFFFF; rst_n low mid-MDU_WAIT -> all outputs at reset values at once.
